// File: rtl/zcmt_dcache_port_arbiter.sv
// Two-requester (LSU / ZCMT table fetch) arbiter for one dcache read port.
// Optional response watchdog: define ZCMT_ARB_TIMEOUT_EN.
module zcmt_dcache_port_arbiter #(
  parameter int ADDR_W         = 34,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              lsu_req_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  output logic              lsu_gnt_o,
  output logic              lsu_rvalid_o,
  output logic [DATA_W-1:0] lsu_rdata_o,
  output logic              lsu_err_o,
  input  logic              zcmt_req_i,
  input  logic [ADDR_W-1:0] zcmt_addr_i,
  output logic              zcmt_gnt_o,
  output logic              zcmt_rvalid_o,
  output logic [DATA_W-1:0] zcmt_rdata_o,
  output logic              zcmt_err_o,
  output logic              dc_req_o,
  output logic [ADDR_W-1:0] dc_addr_o,
  input  logic              dc_gnt_i,
  input  logic              dc_rvalid_i,
  input  logic [DATA_W-1:0] dc_rdata_i,
  output logic              dc_kill_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RVALID,
    DRAIN
  } state_t;

  state_t state_q, state_d;
  logic owner_q, owner_d;
  logic last_q, last_d;
  logic sel;
  logic gnt, rv, err;
  logic [DATA_W-1:0] rdata;
  logic timeout;

`ifdef ZCMT_ARB_TIMEOUT_EN
  logic [9:0] cnt_q;

  assign timeout = (cnt_q == 10'(TIMEOUT_CYCLES - 1));

  // Watchdog: restart on every state change, count while waiting on the cache.
  always_ff @(posedge clk_i) begin
    if (rst_i || state_d != state_q)
      cnt_q <= '0;
    else if (state_q == WAIT_RVALID || state_q == DRAIN)
      cnt_q <= cnt_q + 10'd1;
  end
`else
  // Constant 0 (the legal range excludes 0); keeps the parameter referenced.
  assign timeout = (TIMEOUT_CYCLES == 0);
`endif

  // Round-robin pick on a tie, otherwise whoever is asking.
  assign sel = (lsu_req_i && zcmt_req_i) ? ~last_q : zcmt_req_i;

  // Next-state and port-side outputs; reset forces everything quiet.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    dc_req_o  = 1'b0;
    dc_addr_o = '0;
    dc_kill_o = 1'b0;
    gnt       = 1'b0;
    rv        = 1'b0;
    err       = 1'b0;
    rdata     = '0;
    if (!rst_i) begin
      unique case (state_q)
        IDLE: begin
          if ((lsu_req_i || zcmt_req_i) && !flush_i) begin
            dc_req_o  = 1'b1;
            dc_addr_o = sel ? zcmt_addr_i : lsu_addr_i;
            gnt       = dc_gnt_i;
            owner_d   = sel;
            state_d   = dc_gnt_i ? WAIT_RVALID : WAIT_GNT;
          end
        end
        WAIT_GNT: begin
          if (flush_i) begin
            state_d = IDLE;
          end else begin
            dc_req_o  = 1'b1;
            dc_addr_o = owner_q ? zcmt_addr_i : lsu_addr_i;
            gnt       = dc_gnt_i;
            if (dc_gnt_i) state_d = WAIT_RVALID;
          end
        end
        WAIT_RVALID: begin
          if (dc_rvalid_i) begin
            rv      = 1'b1;
            rdata   = dc_rdata_i;
            last_d  = owner_q;
            state_d = IDLE;
          end else if (flush_i) begin
            dc_kill_o = 1'b1;
            state_d   = DRAIN;
          end else if (timeout) begin
            rv        = 1'b1;
            err       = 1'b1;
            dc_kill_o = 1'b1;
            state_d   = DRAIN;
          end
        end
        DRAIN: begin
          if (dc_rvalid_i || timeout) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign lsu_gnt_o     = gnt & ~owner_d;
  assign zcmt_gnt_o    = gnt & owner_d;
  assign lsu_rvalid_o  = rv & ~owner_q;
  assign zcmt_rvalid_o = rv & owner_q;
  assign lsu_rdata_o   = owner_q ? '0 : rdata;
  assign zcmt_rdata_o  = owner_q ? rdata : '0;
  assign lsu_err_o     = err & ~owner_q;
  assign zcmt_err_o    = err & owner_q;
  assign busy_o        = ~rst_i & (state_q != IDLE);

  // State, owner and round-robin history registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_zcmt_dcache_port_arbiter.sv
// Scoreboard bench for zcmt_dcache_port_arbiter.
// Define ZCMT_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_zcmt_dcache_port_arbiter;
  localparam int AW = 34;
  localparam int DW = 32;
`ifdef ZCMT_ARB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic flush_i = 1'b0;
  logic lsu_req_i = 1'b0;
  logic [AW-1:0] lsu_addr_i = '0;
  logic lsu_gnt_o, lsu_rvalid_o, lsu_err_o;
  logic [DW-1:0] lsu_rdata_o;
  logic zcmt_req_i = 1'b0;
  logic [AW-1:0] zcmt_addr_i = '0;
  logic zcmt_gnt_o, zcmt_rvalid_o, zcmt_err_o;
  logic [DW-1:0] zcmt_rdata_o;
  logic dc_req_o, dc_kill_o, busy_o;
  logic [AW-1:0] dc_addr_o;
  logic dc_gnt_i = 1'b0;
  logic dc_rvalid_i = 1'b0;
  logic [DW-1:0] dc_rdata_i = '0;

  int checks = 0;
  int failures = 0;
  logic [33:0] sb[$];

  always #5 clk = ~clk;

  zcmt_dcache_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .lsu_req_i(lsu_req_i), .lsu_addr_i(lsu_addr_i),
    .lsu_gnt_o(lsu_gnt_o), .lsu_rvalid_o(lsu_rvalid_o),
    .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
    .zcmt_req_i(zcmt_req_i), .zcmt_addr_i(zcmt_addr_i),
    .zcmt_gnt_o(zcmt_gnt_o), .zcmt_rvalid_o(zcmt_rvalid_o),
    .zcmt_rdata_o(zcmt_rdata_o), .zcmt_err_o(zcmt_err_o),
    .dc_req_o(dc_req_o), .dc_addr_o(dc_addr_o),
    .dc_gnt_i(dc_gnt_i), .dc_rvalid_i(dc_rvalid_i),
    .dc_rdata_i(dc_rdata_i), .dc_kill_o(dc_kill_o),
    .busy_o(busy_o)
  );

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic expect_rsp(logic who, logic [31:0] d, logic e);
    sb.push_back({e, who, d});
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every response the DUT presents must match the queue head.
  always @(negedge clk) begin
    logic [33:0] e;
    if (!rst_i) begin
      chk("one_rvalid", 64'(lsu_rvalid_o & zcmt_rvalid_o), 0);
      if (!lsu_rvalid_o) chk("lsu_rdata_quiet", 64'(lsu_rdata_o), 0);
      if (!zcmt_rvalid_o) chk("zcmt_rdata_quiet", 64'(zcmt_rdata_o), 0);
      if (lsu_rvalid_o || zcmt_rvalid_o) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rvalid actual=1 required=0");
        end else begin
          e = sb.pop_front();
          chk("rsp_owner", 64'(zcmt_rvalid_o), 64'(e[32]));
          chk("rsp_data", 64'(lsu_rdata_o | zcmt_rdata_o),
              64'(e[31:0]));
          chk("rsp_err", 64'(lsu_err_o | zcmt_err_o), 64'(e[33]));
        end
      end
    end
  end

  task automatic do_reset;
    rst_i = 1'b1;
    step;
    rst_i = 1'b0;
  endtask

  initial begin
    step;
    step;
    rst_i = 1'b0;
    mid;
    chk("rst_busy", 64'(busy_o), 0);
    chk("rst_dc_req", 64'(dc_req_o), 0);
    chk("rst_dc_addr", 64'(dc_addr_o), 0);
    chk("rst_kill", 64'(dc_kill_o), 0);
    step;

    // LSU-only read, 1-cycle cache
    lsu_req_i = 1'b1;
    lsu_addr_i = 34'h0_0000_1000;
    dc_gnt_i = 1'b1;
    mid;
    chk("t1_lsu_gnt", 64'(lsu_gnt_o), 1);
    chk("t1_zcmt_gnt", 64'(zcmt_gnt_o), 0);
    chk("t1_dc_req", 64'(dc_req_o), 1);
    chk("t1_dc_addr", 64'(dc_addr_o), 64'h1000);
    step;
    lsu_req_i = 1'b0;
    dc_gnt_i = 1'b0;
    dc_rvalid_i = 1'b1;
    dc_rdata_i = 32'hDEADBEEF;
    expect_rsp(1'b0, 32'hDEADBEEF, 1'b0);
    mid;
    chk("t1_wr_no_req", 64'(dc_req_o), 0);
    step;
    dc_rvalid_i = 1'b0;
    dc_rdata_i = '0;
    mid;
    chk("t1_idle", 64'(busy_o), 0);
    step;

    // Round-robin with both requesting after reset
    do_reset;
    lsu_addr_i = 34'h2000;
    zcmt_addr_i = 34'h3004;
    lsu_req_i = 1'b1;
    zcmt_req_i = 1'b1;
    dc_gnt_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dc_rvalid_i = 1'b0;
      mid;
      chk("t2_gnt", {62'd0, zcmt_gnt_o, lsu_gnt_o},
          (i == 1) ? 64'd2 : 64'd1);
      chk("t2_addr", 64'(dc_addr_o),
          (i == 1) ? 64'h3004 : 64'h2000);
      step;
      dc_rvalid_i = 1'b1;
      dc_rdata_i = 32'h100 + 32'(i);
      expect_rsp(i == 1, 32'h100 + 32'(i), 1'b0);
      mid;
      step;
    end
    dc_rvalid_i = 1'b0;
    lsu_req_i = 1'b0;
    zcmt_req_i = 1'b0;
    dc_gnt_i = 1'b0;

    // ZCMT locked through a slow grant while LSU waits
    zcmt_req_i = 1'b1;
    zcmt_addr_i = 34'h3008;
    mid;
    chk("t3_no_gnt", 64'(zcmt_gnt_o), 0);
    chk("t3_addr0", 64'(dc_addr_o), 64'h3008);
    step;
    lsu_req_i = 1'b1;
    lsu_addr_i = 34'h2004;
    for (int k = 0; k < 2; k++) begin
      mid;
      chk("t3_addr_lock", 64'(dc_addr_o), 64'h3008);
      chk("t3_lsu_wait", 64'(lsu_gnt_o), 0);
      step;
    end
    dc_gnt_i = 1'b1;
    mid;
    chk("t3_zcmt_gnt", 64'(zcmt_gnt_o), 1);
    chk("t3_lsu_nogn", 64'(lsu_gnt_o), 0);
    step;
    zcmt_req_i = 1'b0;
    dc_gnt_i = 1'b0;
    dc_rvalid_i = 1'b1;
    dc_rdata_i = 32'hCAFE0001;
    expect_rsp(1'b1, 32'hCAFE0001, 1'b0);
    mid;
    chk("t3_rsp_lsu_nogn", 64'(lsu_gnt_o), 0);
    step;
    dc_rvalid_i = 1'b0;
    dc_gnt_i = 1'b1;
    mid;
    chk("t3_lsu_gnt", 64'(lsu_gnt_o), 1);
    chk("t3_lsu_addr", 64'(dc_addr_o), 64'h2004);
    step;
    lsu_req_i = 1'b0;
    dc_gnt_i = 1'b0;
    dc_rvalid_i = 1'b1;
    dc_rdata_i = 32'hCAFE0002;
    expect_rsp(1'b0, 32'hCAFE0002, 1'b0);
    mid;
    step;
    dc_rvalid_i = 1'b0;

    // Flush in WAIT_RVALID: kill, then drain
    lsu_req_i = 1'b1;
    lsu_addr_i = 34'h40;
    dc_gnt_i = 1'b1;
    mid;
    step;
    lsu_req_i = 1'b0;
    dc_gnt_i = 1'b0;
    flush_i = 1'b1;
    mid;
    chk("t4_kill", 64'(dc_kill_o), 1);
    chk("t4_busy", 64'(busy_o), 1);
    step;
    flush_i = 1'b0;
    zcmt_req_i = 1'b1;
    dc_gnt_i = 1'b1;
    mid;
    chk("t4_kill_pulse", 64'(dc_kill_o), 0);
    chk("t4_drain_noreq", 64'(dc_req_o), 0);
    chk("t4_drain_nogn", 64'(zcmt_gnt_o), 0);
    step;
    zcmt_req_i = 1'b0;
    dc_gnt_i = 1'b0;
    dc_rvalid_i = 1'b1;
    dc_rdata_i = 32'h12345678;
    mid;
    chk("t4_drain_busy", 64'(busy_o), 1);
    step;
    dc_rvalid_i = 1'b0;
    mid;
    chk("t4_idle", 64'(busy_o), 0);
    step;

    // Flush together with rvalid still delivers
    lsu_req_i = 1'b1;
    lsu_addr_i = 34'h44;
    dc_gnt_i = 1'b1;
    mid;
    step;
    lsu_req_i = 1'b0;
    dc_gnt_i = 1'b0;
    flush_i = 1'b1;
    dc_rvalid_i = 1'b1;
    dc_rdata_i = 32'h55AA55AA;
    expect_rsp(1'b0, 32'h55AA55AA, 1'b0);
    mid;
    chk("t5_no_kill", 64'(dc_kill_o), 0);
    step;

    // Flush in IDLE blocks the request; stray rvalid ignored
    lsu_req_i = 1'b1;
    dc_gnt_i = 1'b1;
    dc_rvalid_i = 1'b1;
    dc_rdata_i = 32'hBAD0BAD0;
    mid;
    chk("t5_flush_noreq", 64'(dc_req_o), 0);
    chk("t5_flush_nogn", 64'(lsu_gnt_o), 0);
    step;
    lsu_req_i = 1'b0;
    flush_i = 1'b0;
    dc_gnt_i = 1'b0;
    dc_rvalid_i = 1'b0;
    mid;
    chk("t5_idle", 64'(busy_o), 0);
    step;

    // Reset during WAIT_GNT
    lsu_req_i = 1'b1;
    lsu_addr_i = 34'h80;
    mid;
    step;
    mid;
    chk("t6_wg_busy", 64'(busy_o), 1);
    step;
    rst_i = 1'b1;
    step;
    rst_i = 1'b0;
    lsu_req_i = 1'b0;
    mid;
    chk("t6_busy", 64'(busy_o), 0);
    chk("t6_dc_req", 64'(dc_req_o), 0);
    chk("t6_dc_addr", 64'(dc_addr_o), 0);
    chk("t6_kill", 64'(dc_kill_o), 0);
    step;
    lsu_req_i = 1'b1;
    zcmt_req_i = 1'b1;
    zcmt_addr_i = 34'h300C;
    dc_gnt_i = 1'b1;
    mid;
    chk("t6_tie_lsu", {62'd0, zcmt_gnt_o, lsu_gnt_o}, 64'd1);
    step;
    lsu_req_i = 1'b0;
    zcmt_req_i = 1'b0;
    dc_gnt_i = 1'b0;
    dc_rvalid_i = 1'b1;
    dc_rdata_i = 32'h77;
    expect_rsp(1'b0, 32'h77, 1'b0);
    mid;
    step;
    dc_rvalid_i = 1'b0;

`ifdef ZCMT_ARB_TIMEOUT_EN
    // Watchdog: error response, then drain timeout
    zcmt_req_i = 1'b1;
    dc_gnt_i = 1'b1;
    mid;
    chk("t7_gnt", 64'(zcmt_gnt_o), 1);
    step;
    zcmt_req_i = 1'b0;
    dc_gnt_i = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (c == 8) expect_rsp(1'b1, 32'h0, 1'b1);
      mid;
      chk("t7_kill", 64'(dc_kill_o), (c == 8) ? 64'd1 : 64'd0);
      if (c == 16) chk("t7_drain_busy", 64'(busy_o), 1);
      step;
    end
    mid;
    chk("t7_idle", 64'(busy_o), 0);
    step;
`endif

    step;
    chk("sb_empty", 64'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
